multi_channel_sample_buffer: RTL and testbench

Parametrised per-channel sample history buffer. It generalises the fixed 14-channel × 10-deep × 8-bit broadcast shift buffer with the following additions:
- per-channel or broadcast writes
- per-channel fill counts
- an indexed, registered read port
- a global clear
It sits between the input sampling logic and downstream filtering/readout logic in the tt_um top level.

---
 rtl/multi_channel_sample_buffer.sv | 177 +++++++++++++++++
 tb/tb_multi_channel_sample_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_sample_buffer.sv
// Per-channel sample history buffer: circular storage with fill counts and a registered indexed read.
// Define MCSB_WINDOW_SUM_EN to build per-channel running window sums returned on rd_sum.
module multi_channel_sample_buffer #(
  parameter int unsigned NUM_CHANNELS = 14,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 10,
  localparam int unsigned CH_W  = $clog2(NUM_CHANNELS),
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned SUM_W = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              wr_bcast,
  input  logic [CH_W-1:0]   wr_chan,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_chan,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic              rd_err,
  output logic [SUM_W-1:0]  rd_sum
);

  localparam int unsigned POS_W = IDX_W + 1;

  // Sample storage is deliberately unreset; the fill count masks stale entries.
  logic [DATA_W-1:0] mem_q [NUM_CHANNELS][DEPTH];
  logic [IDX_W-1:0]  wp_q  [NUM_CHANNELS];
  logic [IDX_W-1:0]  wp_d  [NUM_CHANNELS];
  logic [CNT_W-1:0]  cnt_q [NUM_CHANNELS];
  logic [CNT_W-1:0]  cnt_d [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] wr_hit_c;

  logic              rd_chan_ok_c;
  logic [CH_W-1:0]   rd_ch_safe_c;
  logic [CNT_W-1:0]  rd_cnt_c;
  logic              rd_hit_c;
  logic [POS_W-1:0]  rd_pos_c;
  logic [IDX_W-1:0]  rd_slot_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [SUM_W-1:0]  rd_sum_c;

  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [CNT_W-1:0]  rd_count_q;
  logic              rd_err_q;
  logic [SUM_W-1:0]  rd_sum_q;

  // Write target decode; clr drops the write, out-of-range wr_chan matches nothing.
  always_comb begin
    wr_hit_c = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wr_hit_c[c] = wr_en && !clr && (wr_bcast || (wr_chan == CH_W'(c)));
    end
  end

  // Pointer and fill-count next state.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wp_d[c]  = wp_q[c];
      cnt_d[c] = cnt_q[c];
      if (clr) begin
        wp_d[c]  = '0;
        cnt_d[c] = '0;
      end else if (wr_hit_c[c]) begin
        wp_d[c] = (wp_q[c] == IDX_W'(DEPTH - 1)) ? '0 : wp_q[c] + IDX_W'(1);
        if (cnt_q[c] != CNT_W'(DEPTH)) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_hit_c[c]) begin
        mem_q[c][wp_q[c]] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wp_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wp_q[c]  <= wp_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Read lookup: age 0 is the slot just behind the write pointer.
  always_comb begin
    rd_chan_ok_c = ({1'b0, rd_chan} < (CH_W + 1)'(NUM_CHANNELS));
    rd_ch_safe_c = rd_chan_ok_c ? rd_chan : '0;
    rd_cnt_c     = rd_chan_ok_c ? cnt_q[rd_ch_safe_c] : '0;
    rd_hit_c     = rd_chan_ok_c && (CNT_W'(rd_idx) < rd_cnt_c);
    rd_pos_c     = POS_W'(wp_q[rd_ch_safe_c]) + POS_W'(DEPTH - 1) - POS_W'(rd_idx);
    if (rd_pos_c >= POS_W'(DEPTH)) begin
      rd_pos_c = rd_pos_c - POS_W'(DEPTH);
    end
    rd_slot_c = rd_hit_c ? IDX_W'(rd_pos_c) : '0;
    rd_data_c = rd_hit_c ? mem_q[rd_ch_safe_c][rd_slot_c] : '0;
  end

`ifdef MCSB_WINDOW_SUM_EN
  logic [SUM_W-1:0] sum_q [NUM_CHANNELS];
  logic [SUM_W-1:0] sum_d [NUM_CHANNELS];

  // Running sum: add the new sample, subtract the evicted one once the channel is full.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sum_d[c] = sum_q[c];
      if (clr) begin
        sum_d[c] = '0;
      end else if (wr_hit_c[c]) begin
        sum_d[c] = sum_q[c] + SUM_W'(wr_data)
                 - ((cnt_q[c] == CNT_W'(DEPTH)) ? SUM_W'(mem_q[c][wp_q[c]]) : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        sum_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        sum_q[c] <= sum_d[c];
      end
    end
  end

  always_comb begin
    rd_sum_c = rd_hit_c ? sum_q[rd_ch_safe_c] : '0;
  end
`else
  always_comb begin
    rd_sum_c = '0;
  end
`endif

  // Read response register; idle cycles and errors return zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_count_q <= '0;
      rd_err_q   <= 1'b0;
      rd_sum_q   <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_en ? rd_data_c : '0;
      rd_count_q <= rd_en ? rd_cnt_c : '0;
      rd_err_q   <= rd_en && !rd_hit_c;
      rd_sum_q   <= rd_en ? rd_sum_c : '0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_count = rd_count_q;
  assign rd_err   = rd_err_q;
  assign rd_sum   = rd_sum_q;

endmodule

// File: tb/tb_multi_channel_sample_buffer.sv
// Bench for multi_channel_sample_buffer: directed steps plus random traffic against a queue-based history model.
module tb_multi_channel_sample_buffer;

  localparam int NCH   = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 10;
  localparam int CH_W  = 4;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int SUM_W = DW + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             wr_en;
  logic             wr_bcast;
  logic [CH_W-1:0]  wr_chan;
  logic [DW-1:0]    wr_data;
  logic             rd_en;
  logic [CH_W-1:0]  rd_chan;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [DW-1:0]    rd_data;
  logic [CNT_W-1:0] rd_count;
  logic             rd_err;
  logic [SUM_W-1:0] rd_sum;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference history: index 0 of each queue is the newest sample.
  int hist [NCH][$];

  multi_channel_sample_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_bcast (wr_bcast),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_chan  (rd_chan),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_count (rd_count),
    .rd_err   (rd_err),
    .rd_sum   (rd_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_sum(input int ch);
    int s = 0;
    foreach (hist[ch][i]) s += hist[ch][i];
    return s;
  endfunction

  task automatic model_push(input int ch, input int d);
    hist[ch].push_front(d);
    if (hist[ch].size() > DEPTH) void'(hist[ch].pop_back());
  endtask

  // One clock: drive inputs, predict the response from pre-edge history, update history, check.
  task automatic step(input bit rst, input bit cl, input bit we, input bit bc, input int wch,
                      input int wd, input bit re, input int rch, input int rix);
    int  e_data, e_cnt, e_sum;
    bit  e_valid, e_err;
    e_valid = re; e_err = 1'b0; e_data = 0; e_cnt = 0; e_sum = 0;
    if (re) begin
      if (rch >= NCH) begin
        e_err = 1'b1;
      end else begin
        e_cnt = hist[rch].size();
        if (rix >= e_cnt) begin
          e_err = 1'b1;
        end else begin
          e_data = hist[rch][rix];
`ifdef MCSB_WINDOW_SUM_EN
          e_sum = model_sum(rch);
`endif
        end
      end
    end
    if (rst) begin
      e_valid = 1'b0; e_err = 1'b0; e_data = 0; e_cnt = 0; e_sum = 0;
    end
    rst_n    = !rst;
    clr      = cl;
    wr_en    = we;
    wr_bcast = bc;
    wr_chan  = CH_W'(wch);
    wr_data  = DW'(wd);
    rd_en    = re;
    rd_chan  = CH_W'(rch);
    rd_idx   = IDX_W'(rix);
    @(posedge clk);
    if (rst || cl) begin
      for (int c = 0; c < NCH; c++) hist[c].delete();
    end else if (we) begin
      if (bc) begin
        for (int c = 0; c < NCH; c++) model_push(c, wd & 8'hFF);
      end else if (wch < NCH) begin
        model_push(wch, wd & 8'hFF);
      end
    end
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    chk("rd_err",   32'(rd_err),   32'(e_err));
    chk("rd_data",  32'(rd_data),  32'(e_data));
    chk("rd_count", 32'(rd_count), 32'(e_cnt));
    chk("rd_sum",   32'(rd_sum),   32'(e_sum));
  endtask

  task automatic wr1(input int ch, input int d);
    step(0, 0, 1, 0, ch, d, 0, 0, 0);
  endtask

  task automatic rd1(input int ch, input int ix);
    step(0, 0, 0, 0, 0, 0, 1, ch, ix);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_bcast = 1'b0; wr_chan = '0;
    wr_data = '0; rd_en = 1'b0; rd_chan = '0; rd_idx = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);

    // Empty channel read
    rd1(0, 0);
    chk("empty_err", 32'(rd_err), 32'd1);

    // Per-channel writes, back-to-back reads
    wr1(3, 8'h11); wr1(3, 8'h22); wr1(3, 8'h33);
    rd1(3, 0);
    chk("ch3_idx0", 32'(rd_data), 32'h33);
    rd1(3, 1);
    chk("ch3_idx1", 32'(rd_data), 32'h22);
    rd1(3, 2);
    chk("ch3_idx2", 32'(rd_data), 32'h11);
    chk("ch3_cnt", 32'(rd_count), 32'd3);
    rd1(3, 3);

    // Broadcast overflow
    for (int i = 1; i <= 12; i++) step(0, 0, 1, 1, 0, i, 0, 0, 0);
    rd1(13, 0);
    chk("bc_newest", 32'(rd_data), 32'd12);
    rd1(13, 9);
    chk("bc_oldest", 32'(rd_data), 32'd3);
    chk("bc_count", 32'(rd_count), 32'd10);
`ifdef MCSB_WINDOW_SUM_EN
    chk("bc_sum", 32'(rd_sum), 32'd75);
`endif
    rd1(13, 10);
    rd1(15, 0);

    // Same-cycle write and read: read sees pre-write state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 5, 8'hAA, 1, 5, 0);
    chk("rw_same_err", 32'(rd_err), 32'd1);
    rd1(5, 0);
    chk("rw_after", 32'(rd_data), 32'hAA);

    // clr beats a same-cycle write
    for (int i = 0; i < 4; i++) wr1(1, 8'h40 + i);
    step(0, 1, 1, 0, 1, 8'h55, 1, 1, 0);
    chk("clr_preread", 32'(rd_data), 32'h43);
    rd1(1, 0);
    chk("clr_cnt", 32'(rd_count), 32'd0);

    // Out-of-range write dropped
    wr1(2, 8'h10);
    step(0, 0, 1, 0, 14, 8'h77, 0, 0, 0);
    step(0, 0, 1, 0, 15, 8'h78, 0, 0, 0);
    for (int c = 0; c < NCH; c++) rd1(c, 0);

    // Reset during a pending read squashes it
    wr1(7, 8'h99);
    step(1, 0, 0, 0, 0, 0, 1, 7, 0);
    for (int c = 0; c < NCH; c++) rd1(c, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
           $urandom_range(0, 15), $urandom_range(0, 255), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13),
           $urandom_range(0, 11));
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
